mem_read_server: RTL and testbench
==================================

Name: mem_read_server

Overview:
- Memory-side responder for the read-channel memory interface. Drives the memory_read modport end of the channel.
- Accepts a client read request (start address, size in bytes) and streams the requested range as full-width lines from a line-wide synchronous SRAM.
- Flags the final line with last and mem_last_valid.
- Sits between the line SRAM and any client (e.g. an activation/weight fetch unit).

Parameters:
- WORD_WIDTH, 8, bits per word
- NUM_WORDS_IN_LINE, 32, words per line / SRAM row
- ADDR_WIDTH, 19, byte-address width of mem_start_addr and mem_size_bytes
- Derived LINE_BYTES = NUM_WORDS_IN_LINE*WORD_WIDTH/8 (32)
- Derived LB = $clog2(LINE_BYTES) (5)
- Derived LADDR_W = ADDR_WIDTH-LB (14)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  in  1  read request (level), from client
- mem_start_addr  in  ADDR_WIDTH  byte start address; low LB bits ignored (line-aligned)
- mem_size_bytes  in  ADDR_WIDTH  transfer size in bytes
- mem_valid  out  1  mem_data holds a valid line this cycle
- last  out  1  current beat is the final line of the transfer
- mem_data  out  NUM_WORDS_IN_LINE*WORD_WIDTH  line data, word 0 in LSBs
- mem_last_valid  out  LB  byte index of the last valid byte in the final line
- sram_rd_en  out  1  SRAM read strobe
- sram_addr  out  LADDR_W  SRAM line address
- sram_rd_data  in  NUM_WORDS_IN_LINE*WORD_WIDTH  SRAM read data, valid exactly 1 cycle after sram_rd_en
- busy  out  1  transfer in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0, including mem_data, sram_addr and mem_last_valid. Reset mid-transfer aborts immediately; no partial beat, last or mem_valid after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - mem_req=1 and mem_size_bytes!=0: register line_addr=mem_start_addr[ADDR_WIDTH-1:LB], lines_left=ceil(size/LINE_BYTES) (LADDR_W+1 bits, computed as (size+LINE_BYTES-1)>>LB in ADDR_WIDTH+1 bits), lv=(size-1)[LB-1:0]; go to ISSUE.
  - mem_req=1 and size=0: no beats issued; go to DONE.
- ISSUE, each cycle:
  - sram_rd_en=1, sram_addr=line_addr.
  - line_addr increments modulo 2^LADDR_W (wraps 0x3FFF->0x0000).
  - lines_left decrements.
  - When issuing the final line (lines_left==1), go to DRAIN.
- DRAIN: one cycle for the final read to return; then go to DONE.
- DONE: wait until mem_req==0, then go to IDLE. A held request therefore yields exactly one transfer. A new request needs mem_req to drop for at least 1 cycle.
- Beat pipeline:
  - rd_en_q, last_q register sram_rd_en and the "final issue" flag.
  - mem_valid=rd_en_q; last=last_q; mem_data=rd_en_q ? sram_rd_data : 0; mem_last_valid=last_q ? lv : 0.
- Latency and rate:
  - Request sampled on edge k; first sram_rd_en in cycle k+1; first mem_valid in cycle k+2.
  - One line per cycle, no gaps, no backpressure.
  - N lines -> mem_valid high for exactly N consecutive cycles, last high on the Nth only.
- Inputs mem_start_addr and mem_size_bytes are sampled only at acceptance; changes during a transfer are ignored.
- mem_req toggling while busy has no effect until DONE.
- Max size 2^ADDR_WIDTH-1 -> 0x4000 lines; lines_left must not overflow.

Test Plan:
- addr=0x100, size=64, req held -> sram_addr 0x008,0x009 in consecutive cycles; 2 mem_valid beats, last on beat 2, mem_last_valid=31; no second transfer while req stays high.
- addr=0x000, size=33 -> 2 beats, last on beat 2, mem_last_valid=0. Then size=1 -> 1 beat with last=1, mem_last_valid=0.
- size=0 with req -> no sram_rd_en, no mem_valid; busy high until req drops, then IDLE.
- addr=0x7FFE0, size=64 -> sram_addr 0x3FFF then 0x0000; mem_data matches SRAM rows 0x3FFF, 0x0000.
- rst pulse during beat 3 of a 10-line transfer -> mem_valid, last, sram_rd_en and mem_data are 0 on the reset cycle onward. A fresh req (addr=0x40, size=32) then gives 1 beat from line 0x002 with last=1.
- Back-to-back: req low 1 cycle between two 4-line transfers -> each yields 4 contiguous beats; first beat 2 cycles after its accepting edge.

Source files
------------

// File: rtl/mem_read_server.sv
// rtl/mem_read_server.sv - read-channel memory responder streaming SRAM lines
// Accepts (start address, byte size) and returns whole lines, one per cycle, last line flagged.
module mem_read_server #(
   parameter  int WORD_WIDTH        = 8,
   parameter  int NUM_WORDS_IN_LINE = 32,
   parameter  int ADDR_WIDTH        = 19,
   localparam int DW                = NUM_WORDS_IN_LINE*WORD_WIDTH,
   localparam int LINE_BYTES        = DW/8,
   localparam int LB                = $clog2(LINE_BYTES),
   localparam int LADDR_W           = ADDR_WIDTH-LB
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req,
   input  logic [ADDR_WIDTH-1:0] mem_start_addr,
   input  logic [ADDR_WIDTH-1:0] mem_size_bytes,
   output logic                  mem_valid,
   output logic                  last,
   output logic [DW-1:0]         mem_data,
   output logic [LB-1:0]         mem_last_valid,
   output logic                  sram_rd_en,
   output logic [LADDR_W-1:0]    sram_addr,
   input  logic [DW-1:0]         sram_rd_data,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state_q;
   logic [LADDR_W-1:0]  line_addr_q;
   logic [LADDR_W:0]    lines_left_q;
   logic [LB-1:0]       lv_q;
   logic                rd_en_q;
   logic                last_q;

   logic [LADDR_W-1:0]  line_addr_d;
   logic [ADDR_WIDTH:0] size_round;
   logic [LADDR_W:0]    lines_left_d;
   logic [LB-1:0]       lv_d;
   logic                final_issue;

   // Line count is rounded up in one extra bit so the maximum size cannot overflow.
   assign line_addr_d  = LADDR_W'(mem_start_addr >> LB);
   assign size_round   = {1'b0, mem_size_bytes} + (ADDR_WIDTH+1)'(LINE_BYTES-1);
   assign lines_left_d = (LADDR_W+1)'(size_round >> LB);
   assign lv_d         = mem_size_bytes[LB-1:0] - LB'(1);
   assign final_issue  = (state_q == ISSUE) && (lines_left_q == (LADDR_W+1)'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         line_addr_q  <= '0;
         lines_left_q <= '0;
         lv_q         <= '0;
         rd_en_q      <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         rd_en_q <= (state_q == ISSUE);
         last_q  <= final_issue;
         case (state_q)
            IDLE: begin
               if (mem_req) begin
                  if (mem_size_bytes != '0) begin
                     line_addr_q  <= line_addr_d;
                     lines_left_q <= lines_left_d;
                     lv_q         <= lv_d;
                     state_q      <= ISSUE;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            ISSUE: begin
               line_addr_q  <= line_addr_q + LADDR_W'(1);
               lines_left_q <= lines_left_q - (LADDR_W+1)'(1);
               if (final_issue) state_q <= DRAIN;
            end
            DRAIN: state_q <= DONE;
            DONE: begin
               if (!mem_req) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sram_rd_en     = (state_q == ISSUE);
   assign sram_addr      = sram_rd_en ? line_addr_q : '0;
   assign mem_valid      = rd_en_q;
   assign last           = last_q;
   assign mem_data       = rd_en_q ? sram_rd_data : '0;
   assign mem_last_valid = last_q ? lv_q : '0;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_read_server.sv
// tb/tb_mem_read_server.sv - randomized self-checking bench for mem_read_server
// Expected beats and SRAM issues are scheduled per cycle from the byte-range arithmetic.
module tb_mem_read_server;

   localparam int DW = 256;

   logic            clk;
   logic            rst;
   logic            mem_req;
   logic [18:0]     mem_start_addr;
   logic [18:0]     mem_size_bytes;
   logic            mem_valid;
   logic            last;
   logic [DW-1:0]   mem_data;
   logic [4:0]      mem_last_valid;
   logic            sram_rd_en;
   logic [13:0]     sram_addr;
   logic [DW-1:0]   sram_rd_data;
   logic            busy;

   mem_read_server dut (
      .clk(clk), .rst(rst), .mem_req(mem_req),
      .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
      .mem_valid(mem_valid), .last(last), .mem_data(mem_data),
      .mem_last_valid(mem_last_valid), .sram_rd_en(sram_rd_en),
      .sram_addr(sram_addr), .sram_rd_data(sram_rd_data), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_lo = 1;
   int busy_hi = 0;

   logic [DW-1:0] exp_data [int];
   bit            exp_last [int];
   logic [4:0]    exp_lv   [int];
   logic [13:0]   exp_addr [int];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] line_val(input logic [13:0] a);
      logic [DW-1:0] v;
      for (int j = 0; j < 8; j++)
         v[j*32 +: 32] = (({18'd0, a} + 32'd1) * 32'h9E3779B1) ^ (32'(j) * 32'h85EBCA6B);
      return v;
   endfunction

   // SRAM: row contents are a fixed hash of the row address, garbage when not read.
   always @(posedge clk)
      sram_rd_data <= sram_rd_en ? line_val(sram_addr) : {8{$urandom}};

   function automatic int model_lines(input int size);
      return (size + 31) / 32;
   endfunction

   function automatic int model_lv(input int size);
      return (size - 1) % 32;
   endfunction

   task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add_xfer(input int k, input int addr, input int size);
      int n, la, a;
      n  = model_lines(size);
      la = addr / 32;
      for (int i = 0; i < n; i++) begin
         a = (la + i) % 16384;
         exp_addr[k+i]   = 14'(a);
         exp_data[k+1+i] = line_val(14'(a));
         exp_last[k+1+i] = (i == n-1);
         exp_lv[k+1+i]   = (i == n-1) ? 5'(model_lv(size)) : 5'd0;
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {mem_valid, last, sram_rd_en, busy, mem_last_valid, sram_addr, mem_data}, '0);
      end else begin
         if (exp_data.exists(cyc)) begin
            chk("beat", {mem_valid, last, mem_last_valid, mem_data},
                {1'b1, exp_last[cyc], exp_lv[cyc], exp_data[cyc]});
            exp_data.delete(cyc);
            exp_last.delete(cyc);
            exp_lv.delete(cyc);
         end else begin
            chk("no_beat", {mem_valid, last, mem_last_valid, mem_data}, '0);
         end
         if (exp_addr.exists(cyc)) begin
            chk("sram_issue", {sram_rd_en, sram_addr}, {1'b1, exp_addr[cyc]});
            exp_addr.delete(cyc);
         end else begin
            chk("sram_quiet", sram_rd_en, 1'b0);
         end
         chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   task automatic do_xfer(input int addr, input int size, input int extra, input bit toggle);
      int k, n, done_c;
      @(negedge clk);
      mem_req = 1'b1;
      mem_start_addr = 19'(addr);
      mem_size_bytes = 19'(size);
      k = cyc + 1;
      n = model_lines(size);
      add_xfer(k, addr, size);
      busy_lo = k;
      busy_hi = 32'h7fffffff;
      done_c = (n > 0) ? k + n + 1 : k;
      while (cyc < done_c + extra) begin
         @(negedge clk);
         mem_start_addr = 19'($urandom);
         mem_size_bytes = 19'($urandom);
         if (toggle && n > 0 && cyc <= k + n - 1) mem_req = 1'($urandom);
         else mem_req = 1'b1;
      end
      mem_req = 1'b0;
      busy_hi = cyc;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, sz;
      rst = 1'b1;
      mem_req = 1'b0;
      mem_start_addr = '0;
      mem_size_bytes = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("model_lines_64", 32'(model_lines(64)), 32'd2);
      chk("model_lv_64", 32'(model_lv(64)), 32'd31);
      chk("model_lines_33", 32'(model_lines(33)), 32'd2);
      chk("model_lv_33", 32'(model_lv(33)), 32'd0);
      chk("model_lines_max", 32'(model_lines(524287)), 32'd16384);

      fork
         do_xfer(32'h100, 64, 3, 1'b0);
         begin
            @(negedge clk); @(negedge clk);
            chk("t1_addr0", sram_addr, 14'h008);
            @(negedge clk);
            chk("t1_addr1", sram_addr, 14'h009);
            chk("t1_beat1", {mem_valid, last}, 2'b10);
            @(negedge clk);
            chk("t1_beat2", {mem_valid, last, mem_last_valid}, {1'b1, 1'b1, 5'd31});
         end
      join

      fork
         do_xfer(0, 33, 0, 1'b0);
         begin
            repeat (4) @(negedge clk);
            chk("t2_beat2", {mem_valid, last, mem_last_valid}, {1'b1, 1'b1, 5'd0});
         end
      join
      fork
         do_xfer(0, 1, 1, 1'b0);
         begin
            repeat (3) @(negedge clk);
            chk("t2_size1", {mem_valid, last, mem_last_valid}, {1'b1, 1'b1, 5'd0});
         end
      join

      fork
         do_xfer(32'h2345, 0, 4, 1'b0);
         begin
            repeat (2) @(negedge clk);
            chk("t3_zero", {busy, sram_rd_en}, 2'b10);
         end
      join

      fork
         do_xfer(32'h7FFE0, 64, 0, 1'b0);
         begin
            repeat (2) @(negedge clk);
            chk("t4_wrap0", sram_addr, 14'h3FFF);
            @(negedge clk);
            chk("t4_wrap1", sram_addr, 14'h0000);
            chk("t4_data0", mem_data, line_val(14'h3FFF));
            @(negedge clk);
            chk("t4_data1", mem_data, line_val(14'h0000));
         end
      join

      @(negedge clk);
      mem_req = 1'b1;
      mem_start_addr = 19'h12340;
      mem_size_bytes = 19'd320;
      k = cyc + 1;
      add_xfer(k, 32'h12340, 320);
      busy_lo = k;
      busy_hi = 32'h7fffffff;
      while (cyc < k + 2) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      mem_req = 1'b0;
      exp_data.delete();
      exp_last.delete();
      exp_lv.delete();
      exp_addr.delete();
      busy_hi = -1;
      @(negedge clk);
      chk("t5_rst", {mem_valid, last, sram_rd_en, mem_data}, '0);
      @(negedge clk);
      rst = 1'b0;
      fork
         do_xfer(32'h40, 32, 1, 1'b0);
         begin
            repeat (2) @(negedge clk);
            chk("t5_addr", sram_addr, 14'h002);
            @(negedge clk);
            chk("t5_beat", {mem_valid, last, mem_last_valid}, {1'b1, 1'b1, 5'd31});
         end
      join

      do_xfer(32'h1000, 128, 0, 1'b0);
      do_xfer(32'h3F000, 128, 0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: sz = 0;
            1: sz = $urandom_range(1, 64);
            2: sz = $urandom_range(1, 600);
            default: sz = $urandom_range(1, 4096);
         endcase
         do_xfer(int'($urandom_range(0, 524287)), sz, $urandom_range(0, 3), 1'($urandom));
      end

      do_xfer(32'h00020, 524287, 2, 1'b1);

      repeat (4) @(negedge clk);
      chk("all_beats_seen", 32'(exp_data.num()), 32'd0);
      chk("all_issues_seen", 32'(exp_addr.num()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
